fir_engine_param: RTL and testbench

Parametrised successor of the Lab3 FIR core. An N-tap, DATA_W-bit signed FIR filter with coefficient storage and a circular sample buffer held in internal registers, so it needs no external BRAM. Configured over AXI4-Lite with a full B channel, fed over an AXI4-Stream slave, and emits results on an AXI4-Stream master with back-pressure and tlast. Adds output scaling, early-tlast error reporting and optional saturation, none of which the previous core had.

---
 rtl/fir_engine_param.sv | 213 +++++++++++++++++++++
 tb/tb_fir_engine_param.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_engine_param.sv
// N-tap signed FIR: register-file taps and circular sample buffer, AXI4-Lite control,
// AXI4-Stream in/out. Define FIR_SAT_EN to clamp outputs instead of two's-complement wrap.

module fir_engine_param #(
    parameter int TAP_NUM   = 11,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 12,
    parameter int OUT_SHIFT = 0
) (
    input  logic              axis_clk,
    input  logic              axis_rst,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic              rready,
    input  logic [DATA_W-1:0] ss_tdata,
    input  logic              ss_tvalid,
    output logic              ss_tready,
    input  logic              ss_tlast,
    output logic [DATA_W-1:0] sm_tdata,
    output logic              sm_tvalid,
    input  logic              sm_tready,
    output logic              sm_tlast
);
    localparam int PTR_W = $clog2(TAP_NUM);
    localparam int ACC_W = 2 * DATA_W + $clog2(TAP_NUM);

    localparam logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_LEN  = ADDR_W'('h10);
    localparam logic [ADDR_W-1:0] TAP_BASE  = ADDR_W'('h40);
    localparam logic [ADDR_W-1:0] TAP_END   = ADDR_W'('h40 + 4 * TAP_NUM);
    localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);
    localparam logic [PTR_W-1:0]  LAST_K    = PTR_W'(TAP_NUM - 1);
    localparam logic [PTR_W:0]    TAP_EXT   = (PTR_W + 1)'(TAP_NUM);
`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT_IN, S_MAC, S_OUT} state_t;
    state_t state, state_nx;

    logic                     ap_start, ap_done, tlast_err, ap_idle;
    logic [DATA_W-1:0]        data_length, out_cnt, last_idx;
    logic signed [DATA_W-1:0] coef [TAP_NUM];
    logic signed [DATA_W-1:0] sbuf [TAP_NUM];
    logic [PTR_W-1:0]         wr_ptr, k_cnt, rd_idx;
    logic signed [ACC_W-1:0]  acc, prod_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic                     wr_fire, rd_fire, in_fire, out_fire, last_out, mac_last;
    logic [DATA_W-1:0]        ctrl_word, rd_word;

    function automatic logic tap_hit(input logic [ADDR_W-1:0] a);
        return (a >= TAP_BASE) && (a < TAP_END) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [PTR_W-1:0] tap_idx(input logic [ADDR_W-1:0] a);
        return PTR_W'((a - TAP_BASE) >> 2);
    endfunction

    // Position k samples back from p in the circular buffer.
    function automatic logic [PTR_W-1:0] ring_back(input logic [PTR_W-1:0] p,
                                                   input logic [PTR_W-1:0] k);
        if (p >= k) return p - k;
        return PTR_W'({1'b0, p} + TAP_EXT - {1'b0, k});
    endfunction

    function automatic logic [DATA_W-1:0] scale_out(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> OUT_SHIFT;
`ifdef FIR_SAT_EN
        if (s > SAT_MAX) s = SAT_MAX;
        else if (s < SAT_MIN) s = SAT_MIN;
`endif
        return DATA_W'(s);
    endfunction

    assign wr_fire   = awvalid & wvalid & ~bvalid;
    assign awready   = wr_fire;
    assign wready    = wr_fire;
    assign rd_fire   = arvalid & ~rvalid;
    assign arready   = rd_fire;
    assign ap_idle   = (state == S_IDLE);
    assign ss_tready = (state == S_WAIT_IN);
    assign in_fire   = ss_tvalid & ss_tready;
    assign sm_tvalid = (state == S_OUT);
    assign out_fire  = sm_tvalid & sm_tready;
    assign last_idx  = data_length - ONE;
    assign last_out  = (out_cnt == last_idx);
    assign mac_last  = (k_cnt == LAST_K);
    assign sm_tlast  = sm_tvalid & last_out;
    assign sm_tdata  = sm_tvalid ? scale_out(acc) : '0;
    assign ctrl_word = {{(DATA_W-4){1'b0}}, tlast_err, ap_idle, ap_done, ap_start};

    assign rd_idx   = ring_back(wr_ptr, k_cnt);
    assign prod     = coef[k_cnt] * sbuf[rd_idx];
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    always_comb begin
        rd_word = '0;
        if (araddr == ADDR_CTRL)    rd_word = ctrl_word;
        else if (araddr == ADDR_LEN) rd_word = data_length;
        else if (tap_hit(araddr))   rd_word = coef[tap_idx(araddr)];
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (ap_start && (data_length != '0)) state_nx = S_WAIT_IN;
            S_WAIT_IN: if (in_fire) state_nx = S_MAC;
            S_MAC:     if (mac_last) state_nx = S_OUT;
            S_OUT:     if (out_fire) state_nx = last_out ? S_IDLE : S_WAIT_IN;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            ap_start    <= 1'b0;
            ap_done     <= 1'b0;
            tlast_err   <= 1'b0;
            data_length <= '0;
            bvalid      <= 1'b0;
            rvalid      <= 1'b0;
            rdata       <= '0;
            wr_ptr      <= '0;
            k_cnt       <= '0;
            out_cnt     <= '0;
            acc         <= '0;
            for (int i = 0; i < TAP_NUM; i++) begin
                coef[i] <= '0;
                sbuf[i] <= '0;
            end
        end else begin
            if (bvalid && bready) bvalid <= 1'b0;
            if (wr_fire) begin
                bvalid <= 1'b1;
                // Configuration is frozen while a run is in flight; the write is still acknowledged.
                if (ap_idle) begin
                    if ((awaddr == ADDR_CTRL) && wdata[0]) begin
                        ap_start  <= 1'b1;
                        ap_done   <= 1'b0;
                        tlast_err <= 1'b0;
                    end
                    if (awaddr == ADDR_LEN) data_length <= wdata;
                    if (tap_hit(awaddr)) coef[tap_idx(awaddr)] <= $signed(wdata);
                end
            end

            if (rvalid && rready) rvalid <= 1'b0;
            if (rd_fire) begin
                rvalid <= 1'b1;
                rdata  <= rd_word;
                if (araddr == ADDR_CTRL) ap_done <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        ap_start <= 1'b0;
                        if (data_length == '0) begin
                            ap_done <= 1'b1;
                        end else begin
                            wr_ptr  <= '0;
                            out_cnt <= '0;
                            for (int i = 0; i < TAP_NUM; i++) sbuf[i] <= '0;
                        end
                    end
                end
                S_WAIT_IN: begin
                    if (in_fire) begin
                        sbuf[wr_ptr] <= $signed(ss_tdata);
                        acc          <= '0;
                        k_cnt        <= '0;
                        if (ss_tlast && (out_cnt < last_idx)) tlast_err <= 1'b1;
                    end
                end
                S_MAC: begin
                    acc <= acc + prod_ext;
                    if (mac_last) begin
                        k_cnt  <= '0;
                        wr_ptr <= (wr_ptr == LAST_K) ? '0 : wr_ptr + PTR_W'(1);
                    end else begin
                        k_cnt <= k_cnt + PTR_W'(1);
                    end
                end
                S_OUT: begin
                    if (out_fire) begin
                        out_cnt <= out_cnt + ONE;
                        if (last_out) ap_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_engine_param.sv
// Bench for fir_engine_param: convolution reference model with an output scoreboard,
// stall/latency monitor and AXI4-Lite register checks.

module tb_fir_engine_param;
    localparam int TAP_NUM   = 11;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 12;
    localparam int OUT_SHIFT = 0;

    logic              axis_clk = 1'b0;
    logic              axis_rst = 1'b1;
    logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
    logic              awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [DATA_W-1:0] wdata = '0, ss_tdata = '0;
    logic              ss_tvalid = 1'b0, ss_tlast = 1'b0, sm_tready;
    logic              awready, wready, bvalid, arready, rvalid, ss_tready, sm_tvalid, sm_tlast;
    logic [DATA_W-1:0] rdata, sm_tdata;

    fir_engine_param #(.TAP_NUM(TAP_NUM), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_SHIFT(OUT_SHIFT)) dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .ss_tdata(ss_tdata), .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tlast(ss_tlast),
        .sm_tdata(sm_tdata), .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tlast(sm_tlast)
    );

    always #5 axis_clk = ~axis_clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    int tready_mode = 0;
    int tlast_at = -1;
    logic signed [DATA_W-1:0] taps_m [TAP_NUM];
    logic signed [DATA_W-1:0] xs [$];
    logic [DATA_W:0] exp_q [$];
    int in_cyc_q [$];
    logic prev_valid = 1'b0, prev_stall = 1'b0;
    logic [DATA_W:0] prev_out = '0;
    logic [DATA_W-1:0] rd, rd2;
    int exp_lit [11] = '{1, 4, 10, 20, 35, 56, 84, 120, 165, 220, 286};
    int quiet;

    always @(posedge axis_clk) cyc <= cyc + 1;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    // y[n] = sum_k tap[k] * x[n-k], samples before the run are zero.
    function automatic logic [DATA_W-1:0] model_out(int n);
        logic signed [127:0] sum, a, b;
        sum = '0;
        for (int k = 0; k < TAP_NUM; k++) begin
            if (n - k >= 0) begin
                a = taps_m[k];
                b = xs[n-k];
                sum = sum + a * b;
            end
        end
        sum = sum >>> OUT_SHIFT;
`ifdef FIR_SAT_EN
        begin
            logic signed [127:0] lim;
            lim = 128'sd1 <<< (DATA_W - 1);
            if (sum > lim - 1) sum = lim - 1;
            else if (sum < -lim) sum = -lim;
        end
`endif
        return sum[DATA_W-1:0];
    endfunction

    initial begin
        sm_tready = 1'b1;
        forever begin
            @(posedge axis_clk);
            #1;
            case (tready_mode)
                0: sm_tready = 1'b1;
                1: sm_tready = ~sm_tready;
                default: sm_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        logic [DATA_W:0] e;
        int t;
        forever begin
            @(negedge axis_clk);
            if (ss_tvalid && ss_tready) in_cyc_q.push_back(cyc);
            if (prev_stall) check("stall_hold", {sm_tvalid, sm_tlast, sm_tdata}, {1'b1, prev_out});
            if (sm_tvalid && !prev_valid) begin
                if (in_cyc_q.size() == 0) check("pending_inputs", in_cyc_q.size(), 1);
                else begin
                    t = in_cyc_q.pop_front();
                    check("latency", 64'(cyc - t), 64'(TAP_NUM + 1));
                end
            end
            if (sm_tvalid && sm_tready) begin
                if (exp_q.size() == 0) check("unexpected_out", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    check("out", {sm_tlast, sm_tdata}, e);
                end
            end
            prev_valid = sm_tvalid;
            prev_stall = sm_tvalid && !sm_tready;
            prev_out   = {sm_tlast, sm_tdata};
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n = 0;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        do begin @(negedge axis_clk); n++; end while (!awready && n < 200);
        check("awready", awready, 1);
        @(posedge axis_clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge axis_clk);
        check("bvalid", bvalid, 1);
        bready = 1'b1;
        @(posedge axis_clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
        int n = 0;
        araddr = a; arvalid = 1'b1;
        do begin @(negedge axis_clk); n++; end while (!arready && n < 200);
        @(posedge axis_clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 200) begin @(negedge axis_clk); n++; end
        check("rvalid", rvalid, 1);
        d = rdata;
        rready = 1'b1;
        @(posedge axis_clk); #1;
        rready = 1'b0;
    endtask

    task automatic read_check(input string nm, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        logic [DATA_W-1:0] d;
        axi_read(a, d);
        check(nm, d, exp);
    endtask

    task automatic send_sample(input logic [DATA_W-1:0] d, input logic last);
        int n = 0;
        ss_tdata = d; ss_tlast = last; ss_tvalid = 1'b1;
        do begin @(negedge axis_clk); n++; end while (!ss_tready && n < 500);
        check("ss_tready", ss_tready, 1);
        @(posedge axis_clk); #1;
        ss_tvalid = 1'b0; ss_tlast = 1'b0;
    endtask

    task automatic run_begin(input int len, input int tl);
        for (int n = 0; n < len; n++) exp_q.push_back({(n == len - 1), model_out(n)});
        tlast_at = tl;
        axi_write(ADDR_W'('h10), DATA_W'(len));
        axi_write(ADDR_W'(0), DATA_W'(1));
    endtask

    task automatic send_range(input int from, input int upto);
        for (int n = from; n < upto; n++) send_sample(xs[n], n == tlast_at);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin @(negedge axis_clk); n++; end
        check("drain", exp_q.size(), 0);
        repeat (2) @(posedge axis_clk);
        #1;
    endtask

    task automatic write_taps_seq();
        for (int i = 0; i < TAP_NUM; i++) begin
            taps_m[i] = DATA_W'(i + 1);
            axi_write(ADDR_W'('h40 + 4 * i), DATA_W'(i + 1));
        end
    endtask

    initial begin
        for (int i = 0; i < TAP_NUM; i++) taps_m[i] = '0;
        repeat (3) @(posedge axis_clk);
        #1 axis_rst = 1'b0;

        // Reset state
        @(negedge axis_clk);
        check("rst_sm_tvalid", sm_tvalid, 0);
        check("rst_ss_tready", ss_tready, 0);
        check("rst_flags", {bvalid, rvalid, sm_tlast}, 0);
        check("rst_sm_tdata", sm_tdata, 0);
        check("rst_rdata", rdata, 0);
        read_check("rst_ctrl", ADDR_W'(0), 4);
        read_check("rst_len", ADDR_W'('h10), 0);
        read_check("rst_tap0", ADDR_W'('h40), 0);

        // Impulse response through taps 1..11, tlast on the final sample
        write_taps_seq();
        read_check("tap10_rb", ADDR_W'('h40 + 4 * 10), 11);
        xs.delete();
        xs.push_back(1);
        for (int n = 1; n < 11; n++) xs.push_back(0);
        check("model_pin_imp3", model_out(3), 4);
        check("model_pin_imp10", model_out(10), 11);
        tready_mode = 0;
        run_begin(11, 10);
        send_range(0, 11);
        wait_drain();
        read_check("ctrl_done", ADDR_W'(0), 6);
        read_check("ctrl_done_clr", ADDR_W'(0), 4);

        // Ramp input with sm_tready toggling
        xs.delete();
        for (int n = 0; n < 11; n++) xs.push_back(DATA_W'(n + 1));
        for (int n = 0; n < 11; n++) check("model_pin_ramp", model_out(n), 64'(exp_lit[n]));
        tready_mode = 1;
        run_begin(11, -1);
        send_range(0, 11);
        wait_drain();
        read_check("ctrl_ramp", ADDR_W'(0), 6);

        // Tap write during a run is ignored but acknowledged
        xs.delete();
        xs.push_back(2); xs.push_back(3); xs.push_back(4);
        tready_mode = 0;
        run_begin(3, 2);
        send_range(0, 1);
        axi_write(ADDR_W'('h40), 5);
        send_range(1, 3);
        wait_drain();
        read_check("tap0_frozen", ADDR_W'('h40), 1);
        read_check("ctrl_run3", ADDR_W'(0), 6);

        // Zero-length run
        axi_write(ADDR_W'('h10), 0);
        axi_write(ADDR_W'(0), 1);
        quiet = 0;
        repeat (5) begin @(negedge axis_clk); if (ss_tready) quiet++; end
        check("zero_len_no_tready", quiet, 0);
        read_check("ctrl_zero_len", ADDR_W'(0), 6);
        read_check("ctrl_zero_clr", ADDR_W'(0), 4);

        // Concurrent read and write
        fork
            axi_write(ADDR_W'('h10), 7);
            axi_read(ADDR_W'('h44), rd2);
        join
        check("concurrent_rd", rd2, 2);
        read_check("concurrent_wr", ADDR_W'('h10), 7);

        // Random taps, early tlast on sample 3 of 5
        for (int i = 0; i < TAP_NUM; i++) begin
            taps_m[i] = $urandom;
            axi_write(ADDR_W'('h40 + 4 * i), taps_m[i]);
        end
        xs.delete();
        for (int n = 0; n < 5; n++) xs.push_back($urandom);
        tready_mode = 2;
        run_begin(5, 2);
        send_range(0, 5);
        wait_drain();
        read_check("ctrl_tlast_err", ADDR_W'(0), 'hE);
        read_check("ctrl_err_sticky", ADDR_W'(0), 'hC);

        // Longer random run wraps the circular buffer
        xs.delete();
        for (int n = 0; n < 15; n++) xs.push_back($urandom);
        run_begin(15, -1);
        send_range(0, 15);
        wait_drain();
        read_check("ctrl_long", ADDR_W'(0), 6);

        // Reset during MAC aborts the run
        tready_mode = 0;
        xs.delete();
        xs.push_back(9); xs.push_back(8);
        run_begin(2, -1);
        send_range(0, 1);
        repeat (3) @(posedge axis_clk);
        #1 axis_rst = 1'b1;
        @(posedge axis_clk);
        #1 axis_rst = 1'b0;
        exp_q.delete();
        in_cyc_q.delete();
        for (int i = 0; i < TAP_NUM; i++) taps_m[i] = '0;
        @(negedge axis_clk);
        check("abort_sm_tvalid", sm_tvalid, 0);
        check("abort_ss_tready", ss_tready, 0);
        check("abort_flags", {bvalid, rvalid, sm_tlast}, 0);
        check("abort_sm_tdata", sm_tdata, 0);
        read_check("abort_ctrl", ADDR_W'(0), 4);
        read_check("abort_tap0", ADDR_W'('h40), 0);
        read_check("abort_len", ADDR_W'('h10), 0);

        // Full-scale products: wrap or saturate
        taps_m[0] = 32'h7FFF_FFFF;
        taps_m[1] = 32'h7FFF_FFFF;
        axi_write(ADDR_W'('h40), 32'h7FFF_FFFF);
        axi_write(ADDR_W'('h44), 32'h7FFF_FFFF);
        xs.delete();
        xs.push_back(32'h7FFF_FFFF); xs.push_back(32'h7FFF_FFFF);
`ifdef FIR_SAT_EN
        check("model_pin_big0", model_out(0), 32'h7FFF_FFFF);
        check("model_pin_big1", model_out(1), 32'h7FFF_FFFF);
`else
        check("model_pin_big0", model_out(0), 32'h0000_0001);
        check("model_pin_big1", model_out(1), 32'h0000_0002);
`endif
        tready_mode = 2;
        run_begin(2, 1);
        send_range(0, 2);
        wait_drain();
        read_check("ctrl_big", ADDR_W'(0), 6);

        repeat (5) @(posedge axis_clk);
        check("leftover_outputs", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
